serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 29 ++
 rtl/adder_half.sv | 12 +
 rtl/bit_full_adder.sv | 30 +++
 rtl/serial_adder_ctrl.sv | 98 +++++++++
 tb/tb_serial_adder_ctrl.sv | 162 ++++++++++++++++
 6 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle between a producer/consumer and the serial adder.
interface serial_adder_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/adder_half.sv
// One-bit half adder.
module adder_half (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/bit_full_adder.sv
// One-bit full adder built from two half adders; the carries can never both be set.
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  adder_half u_ha0 (
    .a (a),
    .b (b),
    .s (w_s0),
    .c (w_c0)
  );

  adder_half u_ha1 (
    .a (w_s0),
    .b (cin),
    .s (s),
    .c (w_c1)
  );

  assign co = w_c0 | w_c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder step per cycle, WIDTH cycles per operation,
// valid/ready handshakes on both operand and result sides.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic w_fa_s;
  logic w_fa_co;

  bit_full_adder u_fa (
    .a   (r_a[0]),
    .b   (r_b[0]),
    .cin (r_carry),
    .s   (w_fa_s),
    .co  (w_fa_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_carry    <= bus.cin;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StRun;
          end
        end
        StRun: begin
          // LSB-first: each result bit enters at the MSB and walks down.
          r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
          r_carry <= w_fa_co;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_cnt   <= r_cnt + CntOne;
          if (r_cnt == CntLast) begin
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_carry;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8: latency, stall, ignore, reset, throughput.
module tb_serial_adder_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.in_ready && n < 30) begin
      tick();
      n++;
    end
    check_val({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  // Runs one operation; hold = DONE cycles with out_ready low, inject = pulse new
  // operands during RUN.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input int hold, input bit inject, input string tag);
    logic [8:0] exp9;
    int         lat;
    exp9 = 9'(a) + 9'(b) + 9'(ci);
    wait_ready(tag);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    last_acc     = cyc;
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check_val({tag, "_inrdy_run"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = (hold == 0);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      if (inject && lat == 2) begin
        bus.a        = ~a;
        bus.b        = 8'h5C;
        bus.cin      = ~ci;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    check_val({tag, "_lat"}, 32'(lat), 32'(W));
    check_val({tag, "_sum"}, 32'(bus.sum), 32'(exp9[7:0]));
    check_val({tag, "_cout"}, 32'(bus.cout), 32'(exp9[8]));
    for (int i = 0; i < hold; i++) begin
      tick();
      check_val($sformatf("%s_hold%0d_valid", tag, i), 32'(bus.out_valid), 32'd1);
      check_val($sformatf("%s_hold%0d_sum", tag, i), 32'(bus.sum), 32'(exp9[7:0]));
      check_val($sformatf("%s_hold%0d_cout", tag, i), 32'(bus.cout), 32'(exp9[8]));
      check_val($sformatf("%s_hold%0d_inrdy", tag, i), 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    check_val({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_rel_inrdy"}, 32'(bus.in_ready), 32'd1);
    check_val({tag, "_rel_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_inrdy"}, 32'(bus.in_ready), 32'd1);
    check_val({tag, "_sum"}, 32'(bus.sum), 32'd0);
    check_val({tag, "_cout"}, 32'(bus.cout), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int          prev;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check_reset_vals("rst0");
    rst = 1'b0;
    tick();

    do_op(8'h5A, 8'h33, 1'b0, 0, 1'b0, "v5a33");
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, "vff01");
    do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0, "vffff1");
    do_op(8'hA7, 8'h6C, 1'b1, 5, 1'b0, "stall");
    do_op(8'h12, 8'h34, 1'b0, 0, 1'b1, "ignore");

    // Reset three cycles into RUN discards the operation.
    wait_ready("mid");
    bus.a        = 8'hC3;
    bus.b        = 8'h7E;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_vals("midrst");
    do_op(8'h10, 8'h20, 1'b0, 0, 1'b0, "post_rst");

    // Back-to-back with out_ready high: accepts must be W+2 cycles apart.
    prev = last_acc;
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      do_op(r[7:0], r[15:8], r[16], 0, 1'b0, $sformatf("rnd%0d", i));
      if (i > 0) check_val($sformatf("rnd%0d_period", i), 32'(last_acc - prev), 32'(W + 2));
      prev = last_acc;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
